counter_enable_ctrl: RTL

Upstream control stage for the 4-bit first_counter. It generates that counter's `enable` input as a rate-programmable pulse train. The train runs continuously or as a fixed-length burst, under start/stop command control. `enable` connects directly to the counter's `enable` port on the same `clock`.

---
 rtl/counter_enable_ctrl_if.sv | 25 ++
 rtl/counter_enable_ctrl.sv | 100 ++++++++++
 2 files changed

// File: rtl/counter_enable_ctrl_if.sv
// Command/status bundle between the enable controller and whoever drives it.
// The master issues start/stop and rate settings; the slave returns the pulse train and status.
interface counter_enable_ctrl_if #(
    parameter int PRESCALE_W = 8,
    parameter int BURST_W    = 8
);
    logic                  start;
    logic                  stop;
    logic                  mode;
    logic [PRESCALE_W-1:0] prescale;
    logic [BURST_W-1:0]    burst_len;
    logic                  enable;
    logic                  busy;
    logic                  done;

    modport master (
        output start, stop, mode, prescale, burst_len,
        input  enable, busy, done
    );

    modport slave (
        input  start, stop, mode, prescale, burst_len,
        output enable, busy, done
    );
endinterface

// File: rtl/counter_enable_ctrl.sv
// Rate-programmable enable pulse generator feeding the 4-bit first_counter.
// Runs continuously or for a fixed burst of pulses, under start/stop control.
module counter_enable_ctrl #(
    parameter int PRESCALE_W = 8,
    parameter int BURST_W    = 8
) (
    input  logic clock,
    input  logic reset,
    counter_enable_ctrl_if.slave ctrl
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t                state;
    logic [PRESCALE_W-1:0] p_lat;
    logic [PRESCALE_W-1:0] pre_cnt;
    logic [BURST_W-1:0]    remaining;
    logic                  mode_lat;
    logic                  enable_q;
    logic                  busy_q;
    logic                  done_q;

    assign ctrl.enable = enable_q;
    assign ctrl.busy   = busy_q;
    assign ctrl.done   = done_q;

    // remaining counts pulses still owed after the one currently on the output,
    // so a burst ends on the edge after a pulse is seen with remaining == 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            p_lat     <= '0;
            pre_cnt   <= '0;
            remaining <= '0;
            mode_lat  <= 1'b0;
            enable_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    enable_q <= 1'b0;
                    busy_q   <= 1'b0;
                    if (ctrl.start && !ctrl.stop) begin
                        if (!ctrl.mode) begin
                            state    <= RUN;
                            p_lat    <= ctrl.prescale;
                            mode_lat <= 1'b0;
                            pre_cnt  <= '0;
                            enable_q <= 1'b1;
                            busy_q   <= 1'b1;
                        end else if (ctrl.burst_len != '0) begin
                            state     <= BURST;
                            p_lat     <= ctrl.prescale;
                            mode_lat  <= 1'b1;
                            remaining <= ctrl.burst_len - 1'b1;
                            pre_cnt   <= '0;
                            enable_q  <= 1'b1;
                            busy_q    <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN, BURST: begin
                    if (ctrl.stop) begin
                        state    <= IDLE;
                        enable_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else if (mode_lat && enable_q && remaining == '0) begin
                        state    <= IDLE;
                        enable_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else if (pre_cnt == p_lat) begin
                        pre_cnt  <= '0;
                        enable_q <= 1'b1;
                        if (mode_lat && remaining != '0) begin
                            remaining <= remaining - 1'b1;
                        end
                    end else begin
                        pre_cnt  <= pre_cnt + 1'b1;
                        enable_q <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    enable_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule
